ahblite_regbank_slave: RTL and testbench
========================================

Name: ahblite_regbank_slave

Overview:
- AHB-Lite responder: the slave-side endpoint fed by the interconnect's per-slave stage (HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY in, HREADYOUT/HRESP/HRDATA out).
- Holds a flop-based bank of DEPTH 32-bit words with byte/halfword/word access.
- Inserts programmable wait states.
- Returns a two-cycle ERROR response for illegal accesses.
- Used as a scratch/control register target behind the matrix and as the reference slave in matrix verification.

Parameters:
- DEPTH, 16, number of 32-bit words (2..256).
- ADDR_WIDTH, 10, low HADDR bits decoded; HADDR[31:ADDR_WIDTH] ignored; 4*DEPTH <= 2**ADDR_WIDTH.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15).

Ports:
- HCLK  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from interconnect.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; accepted and ignored.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in data phase.
- HMASTLOCK  in  1  accepted and ignored.
- HREADY  in  1  bus-level ready (address phase end).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (aresetn low, asynchronous): state=ADDR, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all bank words=0.
- Accept: accept = HSEL & HTRANS[1] & HREADY.
- IDLE/BUSY, or HSEL=0: no data phase; zero-wait OKAY.
- On accept, latch word index HADDR[ADDR_WIDTH-1:2], HADDR[1:0], HSIZE, HWRITE.
- Error conditions, checked at accept:
  - HSIZE > 3'b010.
  - Halfword access with HADDR[0]=1.
  - Word access with HADDR[1:0] != 00.
  - Word index >= DEPTH.
- States:
  - ADDR: no pending data phase; HREADYOUT=1, HRESP=0. accept&legal -> DATA (wait counter := WAIT_STATES). accept&illegal -> ERR1.
  - DATA: HREADYOUT = (cnt==0), HRESP=0. While cnt != 0, decrement each cycle. When cnt==0, the phase completes at this edge:
    - accept&legal -> DATA (reload counter).
    - accept&illegal -> ERR1.
    - otherwise -> ADDR.
  - ERR1: HREADYOUT=0, HRESP=1; unconditionally -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the same accept rules as the DATA completion cycle, so a transfer presented during ERR2 is serviced normally.
- Write commit:
  - Occurs on the completing edge of a DATA write (cnt==0).
  - Byte strobes come from latched size/offset, little-endian. Byte: lane HADDR[1:0]. Halfword: lanes {1,0} or {3,2}. Word: all lanes.
  - Only strobed bytes are updated from HWDATA.
  - An errored write never modifies the bank.
- Read data:
  - HRDATA = bank[latched index] during a read DATA phase; 0 in all other states.
  - Full word is returned regardless of size.
  - A read whose address phase overlaps the data phase of a write to the same word returns the post-write value, because the write commits on the same edge that starts the read data phase.
- No latency beyond WAIT_STATES: an OKAY data phase lasts WAIT_STATES+1 cycles; an ERROR response lasts exactly 2 cycles.
- Bursts are treated as independent single transfers.
- Reset mid-transfer aborts the transfer silently; the bank returns to 0.

Decomposition:
- Shared package ahblite_pkg:
  - HTRANS encodings.
  - HSIZE encodings (BYTE/HALF/WORD).
  - HRESP_OKAY/HRESP_ERROR.
  - Slave state enum {ADDR, DATA, ERR1, ERR2}.
- Sub-module ahblite_byte_strobe: combinational (HSIZE, HADDR[1:0]) -> 4-bit strobe plus misalign flag. It is reused by other slaves.

Test Plan:
- WAIT_STATES=0: NONSEQ word write 0x0000_0008 data 0xDEADBEEF, then read 0x8 -> HREADYOUT stays 1, HRESP=0, HRDATA=0xDEADBEEF in the read data phase.
- Byte write 0xAA to 0x5, then halfword write 0x1234 to 0x6, over a word initially 0 -> read 0x4 returns 0x1234AA00.
- WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, high on the 4th, with data valid in that cycle; back-to-back NONSEQs each take 4 cycles.
- Word access at 0x2, then HSIZE=3'b011, then index DEPTH -> each gives HREADYOUT 0 then 1 with HRESP=1 for both cycles; an errored write leaves the target word unchanged.
- HSEL=1 with HTRANS=BUSY, then IDLE; and HSEL=0 with NONSEQ -> HREADYOUT=1, HRESP=0, no bank change.
- Assert aresetn low during a WAIT_STATES=2 write data phase -> outputs immediately return to HREADYOUT=1, HRESP=0, HRDATA=0; subsequent read of that word returns 0.

Source files
------------

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, responder state type and byte-merge helper.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_ADDR = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slave_state_e;

  // Replace the byte lanes of old_word selected by strb with those of new_word.
  function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ahblite_byte_strobe.sv
// Little-endian byte-lane strobe and alignment check for an AHB transfer.
// Sizes above a word produce an empty strobe; the caller rejects them.
module ahblite_byte_strobe
  import ahblite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  // Decode size/offset into lanes and flag unaligned half/word accesses.
  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        strb     = 4'b0001 << addr_lo;
        misalign = 1'b0;
      end
      HSIZE_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        strb     = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahblite_regbank_slave.sv
// AHB-Lite register-bank responder: DEPTH flop words, byte/half/word access,
// fixed wait states on OKAY data phases and a two-cycle ERROR response.
module ahblite_regbank_slave
  import ahblite_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        aresetn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AIDX_W = ADDR_WIDTH - 2;

  slave_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        strb_q, strb_d;
  logic              write_q, write_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic [31:0]       bank_q [DEPTH];
  logic [31:0]       bank_d [DEPTH];

  logic              accept_s;
  logic              legal_s;
  logic              idx_ok_s;
  logic              misalign_s;
  logic              take_next_s;
  logic [3:0]        strb_s;
  logic [AIDX_W-1:0] addr_idx_s;
  logic              unused_s;

  // HBURST/HMASTLOCK and the undecoded address bits have no effect here.
  assign unused_s = ^{HBURST, HMASTLOCK, HTRANS[0], HADDR[31:ADDR_WIDTH]};

  assign addr_idx_s = HADDR[ADDR_WIDTH-1:2];
  assign idx_ok_s   = (32'(addr_idx_s) < 32'(DEPTH));
  assign accept_s   = HSEL & HTRANS[1] & HREADY;
  assign legal_s    = (HSIZE <= HSIZE_WORD) & ~misalign_s & idx_ok_s;

  ahblite_byte_strobe u_strobe (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .strb     (strb_s),
    .misalign (misalign_s)
  );

  // Next-state, write-commit and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    strb_d      = strb_q;
    write_d     = write_q;
    bank_d      = bank_q;
    take_next_s = 1'b0;

    case (state_q)
      ST_ADDR: begin
        take_next_s = 1'b1;
      end
      ST_DATA: begin
        if (cnt_q != 4'd0) begin
          cnt_d       = cnt_q - 4'd1;
          take_next_s = 1'b0;
        end else begin
          // Phase completes on this edge; a write lands in the bank now.
          if (write_q) begin
            bank_d[idx_q] = apply_strobe(bank_q[idx_q], HWDATA, strb_q);
          end else begin
            bank_d[idx_q] = bank_q[idx_q];
          end
          take_next_s = 1'b1;
        end
      end
      ST_ERR1: begin
        state_d     = ST_ERR2;
        take_next_s = 1'b0;
      end
      ST_ERR2: begin
        take_next_s = 1'b1;
      end
      default: begin
        state_d     = ST_ADDR;
        take_next_s = 1'b0;
      end
    endcase

    if (take_next_s) begin
      if (accept_s && legal_s) begin
        state_d = ST_DATA;
        cnt_d   = 4'(WAIT_STATES);
        idx_d   = addr_idx_s[IDX_W-1:0];
        strb_d  = strb_s;
        write_d = HWRITE;
      end else if (accept_s) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_ADDR;
      end
    end else begin
      state_d = state_d;
    end

    if (state_d == ST_DATA) begin
      hreadyout_d = (cnt_d == 4'd0);
    end else begin
      hreadyout_d = (state_d != ST_ERR1);
    end
    hresp_d = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Read data comes from the post-commit bank so write->read forwarding is free.
    if ((state_d == ST_DATA) && !write_d) begin
      hrdata_d = bank_d[idx_d];
    end else begin
      hrdata_d = 32'h0000_0000;
    end
  end

  // State, bank and output registers with asynchronous clear.
  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_ADDR;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      strb_q      <= 4'b0000;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      strb_q      <= strb_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      bank_q      <= bank_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahblite_regbank_slave.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) each on its
// own single-slave bus, driven by table vectors, hand sequences and random
// traffic checked against a byte-level memory model.
module tb_ahblite_regbank_slave;
  import ahblite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n;
  logic [2:0]       hsel, hwrite, hmastlock, hreadyout, hresp;
  logic [2:0][31:0] haddr, hwdata, hrdata;
  logic [2:0][1:0]  htrans;
  logic [2:0][2:0]  hsize, hburst;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [3][16];

  ahblite_regbank_slave #(.DEPTH(16), .ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .aresetn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
    .HMASTLOCK(hmastlock[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]), .HRDATA(hrdata[0]));
  ahblite_regbank_slave #(.DEPTH(16), .ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .aresetn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
    .HMASTLOCK(hmastlock[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]), .HRDATA(hrdata[1]));
  ahblite_regbank_slave #(.DEPTH(16), .ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut2 (
    .HCLK(clk), .aresetn(rst_n[2]), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
    .HSIZE(hsize[2]), .HBURST(hburst[2]), .HWRITE(hwrite[2]), .HWDATA(hwdata[2]),
    .HMASTLOCK(hmastlock[2]), .HREADY(hreadyout[2]), .HREADYOUT(hreadyout[2]),
    .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a & 32'h0000_03FF) >> 2);
  endfunction

  // Legal = size up to a word, naturally aligned, word index inside the bank.
  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    int nb;
    if (s > 3'd2) return 1'b0;
    nb = 1 << s;
    if ((a % nb) != 0) return 1'b0;
    return (widx(a) < 16);
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
    int nb;
    int lane;
    nb = 1 << s;
    for (int b = 0; b < nb; b++) begin
      lane = int'(a % 4) + b;
      mem[d][widx(a)][lane*8 +: 8] = wd[lane*8 +: 8];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic go_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE;
  endtask

  // One non-pipelined transfer: address phase, then data phase until ready.
  task automatic do_xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd, output logic [31:0] rd, output int cyc,
                         output logic r_first, output logic r_last);
    bit done;
    @(posedge clk); #1;
    hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; haddr[d] = a; hsize[d] = s; hwrite[d] = wr;
    hburst[d] = 3'($urandom); hmastlock[d] = 1'($urandom);
    @(posedge clk); #1;
    go_idle(d);
    hwdata[d] = wd; haddr[d] = $urandom; hwrite[d] = 1'($urandom);
    cyc = 0; rd = 32'h0; r_first = 1'b0; r_last = 1'b0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) r_first = hresp[d];
      if (hreadyout[d]) begin
        r_last = hresp[d]; rd = hrdata[d]; done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout dut%0d addr 0x%08h: got no HREADYOUT, expected one within 40 cycles", d, a);
    end
  endtask

  // Transfer checked against the model; the model is updated on legal writes.
  task automatic check_xfer(input int d, input logic wr, input logic [31:0] a,
                            input logic [2:0] s, input logic [31:0] wd, input string tag);
    logic [31:0] rd;
    int cyc;
    logic rf, rl;
    bit ok;
    ok = is_legal(a, s);
    do_xfer(d, wr, a, s, wd, rd, cyc, rf, rl);
    if (ok) begin
      chk($sformatf("%s_cycles d%0d a%h", tag, d, a), cyc, ws_of(d) + 1);
      chk($sformatf("%s_resp d%0d a%h", tag, d, a), {rf, rl}, 2'b00);
      if (!wr) chk($sformatf("%s_rdata d%0d a%h", tag, d, a), rd, mem[d][widx(a)]);
      else model_write(d, a, s, wd);
    end else begin
      chk($sformatf("%s_errcycles d%0d a%h", tag, d, a), cyc, 2);
      chk($sformatf("%s_errresp d%0d a%h", tag, d, a), {rf, rl}, 2'b11);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [14];
    logic [31:0] rd, w0, w1;
    int cyc;
    logic rf, rl;

    rst_n = 3'b000; hsel = '0; hwrite = '0; hmastlock = '0; haddr = '0; hwdata = '0;
    htrans = '0; hsize = '0; hburst = '0;
    for (int d = 0; d < 3; d++) for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready d%0d", d), hreadyout[d], 1'b1);
      chk($sformatf("reset_resp d%0d", d), hresp[d], 1'b0);
      chk($sformatf("reset_rdata d%0d", d), hrdata[d], 32'h0);
    end
    rst_n = 3'b111;

    vt[0]  = '{1'b1, 32'h0000_0008, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0008, HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h0000_0005, HSIZE_BYTE, 32'h0000_AA00, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 32'h0000_0006, HSIZE_HALF, 32'h1234_0000, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 32'h0000_0004, HSIZE_WORD, 32'h0,         1'b0, 32'h1234_AA00};
    vt[5]  = '{1'b1, 32'h0000_0002, HSIZE_WORD, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 32'h0000_0000, HSIZE_WORD, 32'h0,         1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h0000_000C, 3'b011,     32'h0,         1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h0000_0040, HSIZE_WORD, 32'h5555_5555, 1'b1, 32'h0};
    vt[9]  = '{1'b0, 32'hFFFF_FC08, HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vt[10] = '{1'b0, 32'h0000_0006, HSIZE_BYTE, 32'h0,         1'b0, 32'h1234_AA00};
    vt[11] = '{1'b1, 32'h0000_0003, HSIZE_HALF, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[12] = '{1'b0, 32'h0000_003C, HSIZE_WORD, 32'h0,         1'b0, 32'h0};
    vt[13] = '{1'b0, 32'h0000_0408, HSIZE_WORD, 32'h0,         1'b0, 32'hDEAD_BEEF};

    for (int i = 0; i < 14; i++) begin
      do_xfer(0, vt[i].wr, vt[i].addr, vt[i].size, vt[i].wdata, rd, cyc, rf, rl);
      chk($sformatf("vec%0d_cycles", i), cyc, vt[i].exp_err ? 2 : 1);
      chk($sformatf("vec%0d_resp", i), {rf, rl}, vt[i].exp_err ? 2'b11 : 2'b00);
      if (!vt[i].wr && !vt[i].exp_err) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      if (vt[i].wr && is_legal(vt[i].addr, vt[i].size)) model_write(0, vt[i].addr, vt[i].size, vt[i].wdata);
    end

    // Write immediately followed by a read of the same word.
    @(posedge clk); #1;
    hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 32'h10; hsize[0] = HSIZE_WORD; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    hwdata[0] = 32'hCAFE_F00D; hwrite[0] = 1'b0;
    @(negedge clk);
    chk("wr_rd_wrphase_ready", hreadyout[0], 1'b1);
    @(posedge clk); #1;
    go_idle(0);
    @(negedge clk);
    model_write(0, 32'h10, HSIZE_WORD, 32'hCAFE_F00D);
    chk("wr_rd_ready", hreadyout[0], 1'b1);
    chk("wr_rd_resp", hresp[0], 1'b0);
    chk("wr_rd_rdata", hrdata[0], 32'hCAFE_F00D);

    // Error response, with the next transfer held until ERR2 accepts it.
    @(posedge clk); #1;
    hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; haddr[0] = 32'h2; hsize[0] = HSIZE_WORD; hwrite[0] = 1'b0;
    @(posedge clk); #1;
    haddr[0] = 32'h8;
    @(negedge clk);
    chk("err1_ready", hreadyout[0], 1'b0);
    chk("err1_resp", hresp[0], 1'b1);
    chk("err1_rdata", hrdata[0], 32'h0);
    @(negedge clk);
    chk("err2_ready", hreadyout[0], 1'b1);
    chk("err2_resp", hresp[0], 1'b1);
    @(posedge clk); #1;
    go_idle(0);
    @(negedge clk);
    chk("after_err_ready", hreadyout[0], 1'b1);
    chk("after_err_resp", hresp[0], 1'b0);
    chk("after_err_rdata", hrdata[0], mem[0][2]);

    // BUSY, IDLE and deselected NONSEQ must not start a data phase.
    @(posedge clk); #1;
    hsel[0] = 1'b1; htrans[0] = HTRANS_BUSY; haddr[0] = 32'h8; hwrite[0] = 1'b1; hwdata[0] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("noxfer%0d_ready", k), hreadyout[0], 1'b1);
      chk($sformatf("noxfer%0d_resp", k), hresp[0], 1'b0);
      @(posedge clk); #1;
      if (k == 0) htrans[0] = HTRANS_IDLE;
      if (k == 1) begin hsel[0] = 1'b0; htrans[0] = HTRANS_NONSEQ; end
    end
    go_idle(0);
    check_xfer(0, 1'b0, 32'h8, HSIZE_WORD, 32'h0, "noxfer_bank");

    // Back-to-back NONSEQ reads with three wait states each.
    w0 = $urandom; w1 = $urandom;
    check_xfer(2, 1'b1, 32'h20, HSIZE_WORD, w0, "b2b_setup");
    check_xfer(2, 1'b1, 32'h24, HSIZE_WORD, w1, "b2b_setup");
    @(posedge clk); #1;
    hsel[2] = 1'b1; htrans[2] = HTRANS_NONSEQ; haddr[2] = 32'h20; hsize[2] = HSIZE_WORD; hwrite[2] = 1'b0;
    @(posedge clk); #1;
    haddr[2] = 32'h24;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), hreadyout[2], (c % 4) == 0);
      if ((c % 4) == 0) chk($sformatf("b2b_rdata_c%0d", c), hrdata[2], (c == 4) ? w0 : w1);
      @(posedge clk); #1;
      if (c == 4) go_idle(2);
    end

    // Random traffic on every responder.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 50; n++) begin
        logic [2:0] s;
        logic [31:0] a;
        s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a = {$urandom} & 32'hFFFF_FC00;
        a = a | 32'($urandom_range(0, 79));
        check_xfer(d, 1'($urandom), a, s, $urandom, "rand");
      end
    end

    // Reset during a wait-stated write data phase.
    @(posedge clk); #1;
    hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 32'hC; hsize[1] = HSIZE_WORD; hwrite[1] = 1'b1;
    @(posedge clk); #1;
    go_idle(1); hwdata[1] = 32'h1122_3344;
    @(negedge clk);
    chk("rst_wait_ready", hreadyout[1], 1'b0);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("rst_async_ready", hreadyout[1], 1'b1);
    chk("rst_async_resp", hresp[1], 1'b0);
    chk("rst_async_rdata", hrdata[1], 32'h0);
    for (int i = 0; i < 16; i++) mem[1][i] = 32'h0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 16; i++) check_xfer(1, 1'b0, 32'(i * 4), HSIZE_WORD, 32'h0, "post_rst");

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
